// File: rtl/ascii_frame_pkg.sv
// ascii_frame_pkg: shared encodings, frame lengths and ASCII constants for the frame scheduler
package ascii_frame_pkg;

  typedef enum logic [1:0] {
    M_TIME  = 2'd0,
    M_DATE  = 2'd1,
    M_SW    = 2'd2,
    M_TIMER = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_e;

  localparam logic [4:0] LEN_TIME  = 5'd10;
  localparam logic [4:0] LEN_DATE  = 5'd16;
  localparam logic [4:0] LEN_SW    = 5'd9;
  localparam logic [4:0] LEN_TIMER = 5'd7;

  localparam logic [7:0] C_COLON    = 8'h3A;
  localparam logic [7:0] C_DASH     = 8'h2D;
  localparam logic [7:0] C_DOT      = 8'h2E;
  localparam logic [7:0] C_SPACE    = 8'h20;
  localparam logic [7:0] C_CR       = 8'h0D;
  localparam logic [7:0] C_LF       = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_BAD  = 8'h3F;

  typedef struct packed {
    logic [23:0] time_bcd;
    logic [31:0] date_bcd;
    logic [3:0]  weekday;
    logic [19:0] sw_bcd;
    logic [15:0] timer_bcd;
  } snap_t;

  function automatic logic [4:0] frame_len(input mode_e m);
    return m == M_TIME ? LEN_TIME : m == M_DATE ? LEN_DATE : m == M_SW ? LEN_SW : LEN_TIMER;
  endfunction

endpackage

// File: rtl/ascii_frame_scheduler_frame_char_mux.sv
// frame_char_mux: selects the ASCII byte at position idx of the frame described by snap and mode
module frame_char_mux
  import ascii_frame_pkg::*;
#(
  parameter int IW = 4
) (
  input  snap_t         snap,
  input  mode_e         mode,
  input  logic [IW-1:0] idx,
  output logic [7:0]    ch
);

  logic [127:0] fr;
  logic [3:0]   b;
  logic [23:0]  t;
  logic [31:0]  d;
  logic [19:0]  s;
  logic [15:0]  r;

  assign b = 4'(idx);
  assign t = snap.time_bcd;
  assign d = snap.date_bcd;
  assign s = snap.sw_bcd;
  assign r = snap.timer_bcd;

  function automatic logic [7:0] asc(input logic [3:0] v);
    return v > 4'd9 ? ASCII_BAD : ASCII_ZERO + {4'h0, v};
  endfunction

  function automatic logic [23:0] wd_txt(input logic [3:0] w);
    case (w)
      4'd0:    return "SUN";
      4'd1:    return "MON";
      4'd2:    return "TUE";
      4'd3:    return "WED";
      4'd4:    return "THU";
      4'd5:    return "FRI";
      4'd6:    return "SAT";
      default: return "MON";
    endcase
  endfunction

  // Whole frame laid out MSB-first, first byte in fr[127:120]; idx picks one byte out of it
  always_comb begin
    fr = mode == M_TIME ? {asc(t[23:20]), asc(t[19:16]), C_COLON, asc(t[15:12]), asc(t[11:8]),
                           C_COLON, asc(t[7:4]), asc(t[3:0]), C_CR, C_LF, 48'h0} :
         mode == M_DATE ? {asc(d[31:28]), asc(d[27:24]), asc(d[23:20]), asc(d[19:16]), C_DASH,
                           asc(d[15:12]), asc(d[11:8]), C_DASH, asc(d[7:4]), asc(d[3:0]),
                           C_SPACE, wd_txt(snap.weekday), C_CR, C_LF} :
         mode == M_SW   ? {asc(s[19:16]), asc(s[15:12]), C_COLON, asc(s[11:8]), asc(s[7:4]),
                           C_DOT, asc(s[3:0]), C_CR, C_LF, 56'h0} :
                          {asc(r[15:12]), asc(r[11:8]), C_COLON, asc(r[7:4]), asc(r[3:0]),
                           C_CR, C_LF, 72'h0};
    ch = fr[{~b, 3'b000} +: 8];
  end

endmodule

// File: rtl/ascii_frame_scheduler.sv
// ascii_frame_scheduler: snapshots BCD clock values and streams them as an ASCII frame over valid/ready
module ascii_frame_scheduler
  import ascii_frame_pkg::*;
#(
  parameter int MAX_FRAME = 16,
  parameter bit PEND_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        update_req,
  input  logic [1:0]  mode,
  input  logic [23:0] time_bcd,
  input  logic [31:0] date_bcd,
  input  logic [3:0]  weekday,
  input  logic [19:0] sw_bcd,
  input  logic [15:0] timer_bcd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam int IW = $clog2(MAX_FRAME);

  state_e        state, state_n;
  logic [IW-1:0] idx, last_idx;
  logic          pending, take, xfer, last;
  snap_t         snap;
  mode_e         smode;
  logic [7:0]    ch;

  assign last_idx = IW'(frame_len(smode) - 5'd1);

  frame_char_mux #(.IW(IW)) u_mux (
    .snap (snap),
    .mode (smode),
    .idx  (idx),
    .ch   (ch)
  );

  // A new frame starts from IDLE on a request, or straight out of DONE when a request is owed
  always_comb begin
    xfer       = state == S_SEND && tx_ready;
    last       = idx == last_idx;
    take       = (state == S_IDLE && update_req) ||
                 (state == S_DONE && (pending || (PEND_EN && update_req)));
    state_n    = state == S_LOAD ? S_SEND :
                 state == S_SEND ? (xfer && last ? S_DONE : S_SEND) :
                 take ? S_LOAD : S_IDLE;
    tx_valid   = state == S_SEND;
    tx_data    = tx_valid ? ch : 8'h00;
    busy       = state != S_IDLE;
    frame_done = state == S_DONE;
  end

  // State register; reset drops tx_valid at once since outputs decode the state directly
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state <= S_IDLE;
    else         state <= state_n;
  end

  // Snapshot capture, byte index and the single merged pending request
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      idx     <= '0;
      pending <= 1'b0;
      snap    <= '0;
      smode   <= M_TIME;
    end else begin
      if (take) begin
        snap  <= '{time_bcd, date_bcd, weekday, sw_bcd, timer_bcd};
        smode <= mode_e'(mode);
      end
      if (state == S_LOAD)     idx <= '0;
      else if (xfer && !last)  idx <= idx + 1'b1;
      pending <= (state == S_IDLE || take) ? 1'b0 : pending | (PEND_EN && update_req);
    end
  end

endmodule
